switch_bounce_gen: RTL and testbench

Synthesizable SPDT pushbutton contact emulator: converts a clean press/release command into the active-low NO/NC contact pair, including break-before-make travel gaps and contact bounce. It drives the lab bounceless-switch (SR-latch) input pair, so debouncing logic can be exercised on the board and in simulation without a mechanical switch. Bounce timing is deterministic by default, with optional LFSR jitter.

---
 rtl/switch_bounce_pkg.sv | 17 +
 rtl/switch_bounce_gen_lfsr8.sv | 25 ++
 rtl/switch_bounce_gen.sv | 154 +++++++++++++++
 tb/tb_switch_bounce_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_bounce_pkg.sv
// Shared types and constants for the SPDT contact emulator.
package switch_bounce_pkg;

  typedef enum logic [2:0] {
    REST_OFF,
    TRAVEL_ON,
    BOUNCE_ON,
    REST_ON,
    TRAVEL_OFF,
    BOUNCE_OFF
  } sb_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/switch_bounce_gen_lfsr8.sv
// 8-bit Fibonacci LFSR used to jitter bounce segment lengths.
module lfsr8
  import switch_bounce_pkg::*;
(
  input  logic       CLKIN,
  input  logic       RESET,
  input  logic       EN,
  output logic [7:0] Q
);

  logic [7:0] lfsr_q;
  logic       feedback;

  assign feedback = ^(lfsr_q & LFSR_TAPS);
  assign Q        = lfsr_q;

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      lfsr_q <= LFSR_SEED;
    end else if (EN) begin
      lfsr_q <= {lfsr_q[6:0], feedback};
    end
  end

endmodule

// File: rtl/switch_bounce_gen.sv
// Pushbutton contact emulator: turns a clean PRESS level into active-low NO/NC
// contacts with break-before-make travel and contact bounce.
module switch_bounce_gen
  import switch_bounce_pkg::*;
#(
  parameter int         TRAVEL      = 4,
  parameter int         BOUNCES     = 3,
  parameter int         BOUNCE_LEN  = 2,
  parameter logic [7:0] JITTER_MASK = 8'h00
) (
  input  logic CLKIN,
  input  logic RESET,
  input  logic PRESS,
  output logic NO,
  output logic NC,
  output logic BUSY,
  output logic DONE
);

  localparam int SEG_MAX = BOUNCE_LEN + 255;
  localparam int CNT_MAX = (SEG_MAX > TRAVEL) ? SEG_MAX : TRAVEL;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BSEGS   = (BOUNCES > 0) ? (2 * BOUNCES - 1) : 0;
  localparam int BW      = (BSEGS > 0) ? $clog2(BSEGS + 1) : 1;

  localparam logic [CW-1:0] TRAVEL_M1   = CW'(TRAVEL - 1);
  localparam logic [CW-1:0] BLEN_M1     = CW'(BOUNCE_LEN - 1);
  localparam logic [BW-1:0] BSEGS_LAST  = BW'(BSEGS);

  sb_state_e     state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [BW-1:0] bcnt_q, bcnt_n;
  logic [7:0]    lfsr_val;
  logic [CW-1:0] seg_len_m1;
  logic          no_n, nc_n, busy_n, done_n;
  logic          rest_q, rest_n;

  lfsr8 u_lfsr (
    .CLKIN (CLKIN),
    .RESET (RESET),
    .EN    (1'b1),
    .Q     (lfsr_val)
  );

  assign seg_len_m1 = BLEN_M1 + CW'(lfsr_val & JITTER_MASK);
  assign rest_q     = (state_q == REST_OFF) || (state_q == REST_ON);
  assign rest_n     = (state_n == REST_OFF) || (state_n == REST_ON);

  // cnt_q holds remaining cycles of the current travel/segment minus one;
  // bcnt_q holds segments still to come, odd = closed segment.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bcnt_n  = bcnt_q;
    case (state_q)
      REST_OFF: begin
        if (PRESS) begin
          state_n = TRAVEL_ON;
          cnt_n   = TRAVEL_M1;
        end
      end
      REST_ON: begin
        if (!PRESS) begin
          state_n = TRAVEL_OFF;
          cnt_n   = TRAVEL_M1;
        end
      end
      TRAVEL_ON, TRAVEL_OFF: begin
        if (cnt_q == '0) begin
          if (BOUNCES == 0) begin
            state_n = (state_q == TRAVEL_ON) ? REST_ON : REST_OFF;
          end else begin
            state_n = (state_q == TRAVEL_ON) ? BOUNCE_ON : BOUNCE_OFF;
            cnt_n   = seg_len_m1;
            bcnt_n  = BSEGS_LAST;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      BOUNCE_ON, BOUNCE_OFF: begin
        if (cnt_q == '0) begin
          if (bcnt_q == '0) begin
            state_n = (state_q == BOUNCE_ON) ? REST_ON : REST_OFF;
          end else begin
            bcnt_n = bcnt_q - 1'b1;
            cnt_n  = seg_len_m1;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_n = REST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    no_n   = 1'b1;
    nc_n   = 1'b0;
    busy_n = 1'b0;
    done_n = rest_n && !rest_q;
    case (state_n)
      REST_OFF: begin
        no_n = 1'b1;
        nc_n = 1'b0;
      end
      REST_ON: begin
        no_n = 1'b0;
        nc_n = 1'b1;
      end
      TRAVEL_ON, TRAVEL_OFF: begin
        no_n   = 1'b1;
        nc_n   = 1'b1;
        busy_n = 1'b1;
      end
      BOUNCE_ON: begin
        no_n   = ~bcnt_n[0];
        nc_n   = 1'b1;
        busy_n = 1'b1;
      end
      BOUNCE_OFF: begin
        no_n   = 1'b1;
        nc_n   = ~bcnt_n[0];
        busy_n = 1'b1;
      end
      default: begin
        no_n = 1'b1;
        nc_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q <= REST_OFF;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      NO      <= 1'b1;
      NC      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bcnt_q  <= bcnt_n;
      NO      <= no_n;
      NC      <= nc_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
    end
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen: default timing, mid-bounce command
// changes, reset during bounce, zero-bounce make and jittered segment lengths.
module tb_switch_bounce_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic press = 1'b0;
  logic press_b0 = 1'b0;
  logic press_j = 1'b0;
  logic no_d, nc_d, busy_d, done_d;
  logic no_b0, nc_b0, busy_b0, done_b0;
  logic no_j, nc_j, busy_j, done_j;
  logic mon_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_bounce_gen u_dut (
    .CLKIN (clk), .RESET (reset), .PRESS (press),
    .NO (no_d), .NC (nc_d), .BUSY (busy_d), .DONE (done_d)
  );

  switch_bounce_gen #(.BOUNCES(0)) u_b0 (
    .CLKIN (clk), .RESET (reset), .PRESS (press_b0),
    .NO (no_b0), .NC (nc_b0), .BUSY (busy_b0), .DONE (done_b0)
  );

  switch_bounce_gen #(.JITTER_MASK(8'h03)) u_jit (
    .CLKIN (clk), .RESET (reset), .PRESS (press_j),
    .NO (no_j), .NC (nc_j), .BUSY (busy_j), .DONE (done_j)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected level of the bouncing contact m cycles after the sampling edge
  // (TRAVEL=4, BOUNCES=3, BOUNCE_LEN=2): open in travel, 2-cycle segments from 5.
  function automatic logic bounce_level(input int m);
    if (m <= 4) return 1'b1;
    if (m >= 17) return 1'b0;
    return (((m - 5) / 2) % 2) != 0;
  endfunction

  task automatic expect_press(input int m);
    check("press_no", no_d, bounce_level(m));
    check("press_nc", nc_d, 1'b1);
    check("press_busy", busy_d, m < 17);
    check("press_done", done_d, m == 17);
  endtask

  task automatic expect_release(input int m);
    check("rel_no", no_d, 1'b1);
    check("rel_nc", nc_d, bounce_level(m));
    check("rel_busy", busy_d, m < 17);
    check("rel_done", done_d, m == 17);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_dut", no_d | nc_d, 1'b1);
      check("inv_b0", no_b0 | nc_b0, 1'b1);
      check("inv_jit", no_j | nc_j, 1'b1);
    end
  end

  initial begin
    int seg_len [$];
    int cur_len;
    logic cur_lvl;
    int guard;

    // Reset and idle stability
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_no", no_d, 1'b1);
    check("rst_nc", nc_d, 1'b0);
    check("rst_busy", busy_d, 1'b0);
    check("rst_done", done_d, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_no", no_d, 1'b1);
      check("idle_nc", nc_d, 1'b0);
      check("idle_busy", busy_d, 1'b0);
      check("idle_done", done_d, 1'b0);
    end

    // Press with defaults, then hold one more rest cycle
    press = 1'b1;
    for (int m = 1; m <= 17; m++) begin
      tick();
      expect_press(m);
    end
    tick();
    check("hold_done", done_d, 1'b0);
    check("hold_no", no_d, 1'b0);

    // Release with defaults
    press = 1'b0;
    for (int m = 1; m <= 17; m++) begin
      tick();
      expect_release(m);
    end

    // Drop PRESS mid-bounce: make completes, release follows from the next cycle
    press = 1'b1;
    for (int m = 1; m <= 17; m++) begin
      tick();
      expect_press(m);
      if (m == 8) press = 1'b0;
    end
    for (int m = 1; m <= 17; m++) begin
      tick();
      expect_release(m);
    end

    // Reset during BOUNCE_ON with PRESS held
    press = 1'b1;
    for (int m = 1; m <= 10; m++) begin
      tick();
      expect_press(m);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_no", no_d, 1'b1);
    check("midrst_nc", nc_d, 1'b0);
    check("midrst_busy", busy_d, 1'b0);
    check("midrst_done", done_d, 1'b0);
    for (int m = 1; m <= 17; m++) begin
      tick();
      expect_press(m);
    end

    // BOUNCES=0: clean make right after travel
    press_b0 = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      tick();
      check("b0_no", no_b0, m < 5);
      check("b0_nc", nc_b0, 1'b1);
      check("b0_busy", busy_b0, m < 5);
      check("b0_done", done_b0, m == 5);
    end

    // JITTER_MASK=3: every bounce segment lasts 2..5 cycles
    press_j = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      tick();
      check("jit_travel_no", no_j, 1'b1);
      check("jit_travel_nc", nc_j, 1'b1);
    end
    tick();
    check("jit_first_make", no_j, 1'b0);
    cur_lvl = no_j;
    cur_len = 1;
    guard = 0;
    while (1) begin
      tick();
      guard++;
      if (guard > 200) begin
        check("jit_timeout", 1'b1, 1'b0);
        break;
      end
      if (done_j) begin
        seg_len.push_back(cur_len);
        break;
      end
      if (no_j === cur_lvl) begin
        cur_len++;
      end else begin
        seg_len.push_back(cur_len);
        cur_lvl = no_j;
        cur_len = 1;
      end
    end
    check("jit_nsegs", seg_len.size(), 6);
    foreach (seg_len[i]) begin
      check("jit_seg_range", (seg_len[i] >= 2) && (seg_len[i] <= 5), 1'b1);
    end
    check("jit_rest_no", no_j, 1'b0);
    check("jit_rest_busy", busy_j, 1'b0);

    tick();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
